// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with a per-register busy scoreboard for RAW/WAW hazard tracking.
// Optional same-cycle write-to-read bypass is built when REGFILE_SCOREBOARD_BYPASS_EN is defined.
module regfile_scoreboard #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NRD*$clog2(NREGS)-1:0]    rd_addr_i,
    output logic [NRD*XLEN-1:0]             rd_data_o,
    output logic [NRD-1:0]                  rd_busy_o,
    input  logic                            claim_valid_i,
    input  logic [$clog2(NREGS)-1:0]        claim_addr_i,
    output logic                            claim_ready_o,
    input  logic [NWR-1:0]                  wr_en_i,
    input  logic [NWR*$clog2(NREGS)-1:0]    wr_addr_i,
    input  logic [NWR*XLEN-1:0]             wr_data_i,
    output logic [$clog2(NREGS):0]          busy_count_o
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             wr_hit;

    // A claim is refused only while its target is pending and not being released this cycle
    always_comb begin
        wr_hit = 1'b0;
        for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == claim_addr_i)) begin
                wr_hit = 1'b1;
            end
        end
        claim_ready_o = claim_valid_i &&
                        ((claim_addr_i == '0) || !busy_q[claim_addr_i] || wr_hit);
    end

    // Next state: writes applied highest port first so port 0 lands last, then claim-set overrides clear
    always_comb begin
        regs_d  = regs_q;
        busy_d  = busy_q;
        count_d = '0;
        for (int w = int'(NWR) - 1; w >= 0; w--) begin
            if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] != '0)) begin
                regs_d[wr_addr_i[w*AW +: AW]] = wr_data_i[w*XLEN +: XLEN];
                busy_d[wr_addr_i[w*AW +: AW]] = 1'b0;
            end
        end
        if (claim_ready_o && (claim_addr_i != '0)) begin
            busy_d[claim_addr_i] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
        if (rst_i) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_d[i] = '0;
            end
            busy_d = '0;
        end
        for (int unsigned i = 0; i < NREGS; i++) begin
            count_d = count_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        regs_q  <= regs_d;
        busy_q  <= busy_d;
        count_q <= count_d;
    end

    // Combinational read ports; register 0 reads as an idle zero
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        for (int unsigned p = 0; p < NRD; p++) begin
            if (rd_addr_i[p*AW +: AW] != '0) begin
                rd_data_o[p*XLEN +: XLEN] = regs_q[rd_addr_i[p*AW +: AW]];
                rd_busy_o[p]              = busy_q[rd_addr_i[p*AW +: AW]];
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
                for (int w = int'(NWR) - 1; w >= 0; w--) begin
                    if (wr_en_i[w] && (wr_addr_i[w*AW +: AW] == rd_addr_i[p*AW +: AW])) begin
                        rd_data_o[p*XLEN +: XLEN] = wr_data_i[w*XLEN +: XLEN];
                        rd_busy_o[p]              = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign busy_count_o = count_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard (NWR=2, NRD=2): directed scenarios with literal expectations,
// plus an array-based model checked against the DUT every cycle.
module tb_regfile_scoreboard;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NRD*AW-1:0]    rd_addr = '0;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 claim_valid = 1'b0;
    logic [AW-1:0]        claim_addr = '0;
    logic                 claim_ready;
    logic [NWR-1:0]       wr_en = '0;
    logic [NWR*AW-1:0]    wr_addr = '0;
    logic [NWR*XLEN-1:0]  wr_data = '0;
    logic [AW:0]          busy_count;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .rd_busy_o     (rd_busy),
        .claim_valid_i (claim_valid),
        .claim_addr_i  (claim_addr),
        .claim_ready_o (claim_ready),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .busy_count_o  (busy_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] wa(input int w);
        return wr_addr[w*AW +: AW];
    endfunction

    // Spec-level view of a read: stored value, overridden by a same-cycle write when bypass exists
    function automatic void model_read(input int a, output logic [63:0] d, output logic b);
        d = (a == 0) ? 64'h0 : m_regs[a];
        b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
        if (a != 0) begin
            if (wr_en[1] && int'(wa(1)) == a) begin d = wr_data[64 +: 64]; b = 1'b0; end
            if (wr_en[0] && int'(wa(0)) == a) begin d = wr_data[0 +: 64];  b = 1'b0; end
        end
`endif
    endfunction

    function automatic logic model_ready();
        logic hit;
        hit = (wr_en[0] && wa(0) == claim_addr) || (wr_en[1] && wa(1) == claim_addr);
        return claim_valid && (claim_addr == '0 || !m_busy[claim_addr] || hit);
    endfunction

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    // Model state update at each edge
    always @(posedge clk) begin
        logic acc;
        acc = model_ready();
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
        end else begin
            for (int w = NWR - 1; w >= 0; w--) begin
                if (wr_en[w] && wa(w) != 0) begin
                    m_regs[wa(w)] = wr_data[w*64 +: 64];
                    m_busy[wa(w)] = 1'b0;
                end
            end
            if (acc && claim_addr != 0) m_busy[claim_addr] = 1'b1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [63:0] d;
        logic b;
        if (started) begin
            for (int p = 0; p < NRD; p++) begin
                model_read(int'(rd_addr[p*AW +: AW]), d, b);
                check($sformatf("model rd_data[%0d]", p), rd_data[p*64 +: 64], d);
                check($sformatf("model rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(b));
            end
            check("model claim_ready", 64'(claim_ready), 64'(model_ready()));
            check("model busy_count", 64'(busy_count), 64'(model_count()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; claim_valid = 1'b0; claim_addr = '0;
        wr_en = '0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic set_wr(input int w, input int a, input logic [63:0] d);
        wr_en[w] = 1'b1;
        wr_addr[w*AW +: AW] = AW'(a);
        wr_data[w*64 +: 64] = d;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
        idle();
        rst = 1'b1;
        step(); step();
        idle();
        started = 1'b1;

        // Reset clears a preloaded register
        set_wr(0, 5, 64'hDEAD); step(); idle();
        set_rd(0, 5); sample();
        check("preload r5", rd_data[63:0], 64'hDEAD);
        step();
        rst = 1'b1; step(); idle();
        sample();
        check("reset r5 data", rd_data[63:0], 64'h0);
        check("reset r5 busy", 64'(rd_busy[0]), 64'h0);
        check("reset count", 64'(busy_count), 64'h0);
        step();

        // Claim then write
        claim_valid = 1'b1; claim_addr = 5'd3; sample();
        check("claim r3 ready", 64'(claim_ready), 64'h1);
        step(); idle();
        set_rd(0, 3); sample();
        check("r3 busy", 64'(rd_busy[0]), 64'h1);
        check("count after claim", 64'(busy_count), 64'h1);
        step();
        set_wr(0, 3, 64'h1234); step(); idle();
        sample();
        check("r3 data", rd_data[63:0], 64'h1234);
        check("r3 released", 64'(rd_busy[0]), 64'h0);
        check("count after write", 64'(busy_count), 64'h0);
        step();

        // Register 0
        set_wr(0, 0, 64'hFFFF); claim_valid = 1'b1; claim_addr = 5'd0; sample();
        check("x0 claim ready", 64'(claim_ready), 64'h1);
        step(); idle();
        set_rd(0, 0); set_rd(1, 0); sample();
        check("x0 data", rd_data[63:0], 64'h0);
        check("x0 busy", 64'(rd_busy), 64'h0);
        check("x0 count", 64'(busy_count), 64'h0);
        step();

        // WAW refusal, then reclaim alongside a release
        claim_valid = 1'b1; claim_addr = 5'd7; step();
        set_rd(0, 7); sample();
        check("r7 reclaim refused", 64'(claim_ready), 64'h0);
        step(); idle();
        sample();
        check("r7 still busy", 64'(rd_busy[0]), 64'h1);
        check("count r7", 64'(busy_count), 64'h1);
        step();
        claim_valid = 1'b1; claim_addr = 5'd7; set_wr(0, 7, 64'h55); sample();
        check("r7 reclaim with write", 64'(claim_ready), 64'h1);
        step(); idle();
        sample();
        check("r7 new data", rd_data[63:0], 64'h55);
        check("r7 busy again", 64'(rd_busy[0]), 64'h1);
        check("count r7 again", 64'(busy_count), 64'h1);
        step();

        // Dual-write collision
        set_wr(0, 9, 64'hAA); set_wr(1, 9, 64'hBB); step(); idle();
        set_rd(0, 9); sample();
        check("r9 port0 wins", rd_data[63:0], 64'hAA);
        step();

        // Bypass on port 1
        set_wr(1, 4, 64'h10); step(); idle();
        claim_valid = 1'b1; claim_addr = 5'd4; step(); idle();
        set_rd(1, 4); set_wr(0, 4, 64'h20); sample();
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
        check("bypass data", rd_data[127:64], 64'h20);
        check("bypass busy", 64'(rd_busy[1]), 64'h0);
`else
        check("no-bypass data", rd_data[127:64], 64'h10);
        check("no-bypass busy", 64'(rd_busy[1]), 64'h1);
`endif
        step(); idle();
        sample();
        check("r4 after write", rd_data[127:64], 64'h20);
        check("r4 released", 64'(rd_busy[1]), 64'h0);
        step();

        // Mixed traffic on a narrow address range to provoke collisions
        for (int n = 0; n < 400; n++) begin
            rst         = ($urandom_range(0, 59) == 0);
            claim_valid = $urandom_range(0, 1) != 0;
            claim_addr  = AW'($urandom_range(0, 7));
            wr_en       = NWR'($urandom_range(0, 3));
            wr_addr     = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            wr_data     = {$urandom, $urandom, $urandom, $urandom};
            rd_addr     = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            step();
        end

        // Reset mid-operation drops pending claims
        idle();
        claim_valid = 1'b1; claim_addr = 5'd12; step();
        claim_addr = 5'd13; step();
        idle(); rst = 1'b1; step(); idle();
        sample();
        check("count after mid reset", 64'(busy_count), 64'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-port integer register file with a per-register busy scoreboard, replacing the fixed 2-read/1-write register file in the pipelined CPU. The decode stage reads operands and claims destination registers. The writeback stage writes results and releases those claims. Decode uses the busy flags to stall on RAW hazards.

## Interface
Parameters:
- XLEN, 64, data width of each register
- NREGS, 32, number of architectural registers; power of 2, ≥ 2; AW = $clog2(NREGS)
- NRD, 2, number of read ports, 1..4
- NWR, 1, number of write ports, 1..2; a lower index has priority

Ports:
- clk_i  in  1  clock; everything is sampled on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- rd_addr_i  in  NRD*AW  read addresses; port p occupies slice [p*AW +: AW]
- rd_data_o  out  NRD*XLEN  read data, combinational
- rd_busy_o  out  NRD  1 = the addressed register has an outstanding claim
- claim_valid_i  in  1  decode requests to mark claim_addr_i busy
- claim_addr_i  in  AW  destination register being claimed
- claim_ready_o  out  1  claim is accepted this cycle, combinational
- wr_en_i  in  NWR  writeback enables
- wr_addr_i  in  NWR*AW  writeback addresses
- wr_data_i  in  NWR*XLEN  writeback data
- busy_count_o  out  $clog2(NREGS)+1  number of busy registers (popcount of the busy array)

## Operation
- Storage: REGS[NREGS] of XLEN bits and BUSY[NREGS] of 1 bit.
- Register 0 is hardwired:
  - reads of register 0 return 0 with busy = 0;
  - writes to register 0 are dropped;
  - a claim of register 0 is always accepted and has no effect.
- Read port p:
  - rd_data_o[p] = REGS[addr];
  - rd_busy_o[p] = BUSY[addr];
  - subject to the bypass rule in Configuration.
- Write:
  - at each edge, for each w with wr_en_i[w] and a nonzero address, REGS[addr] <= data and BUSY[addr] <= 0;
  - if both write ports target the same address, port 0's data wins.
- Claim:
  - claim_ready_o = claim_valid_i & (addr == 0 | !BUSY[addr] | some wr_en_i[w] targets addr this cycle);
  - when accepted with a nonzero address, BUSY[addr] <= 1;
  - claim-set takes priority over write-clear on the same address, so the register ends busy with the new data stored;
  - a refused claim (a WAW hazard on a still-pending register) changes no state; decode must hold the request and retry.
- A write to a register that is not busy is legal: the data is stored and BUSY stays 0.
- busy_count_o is the popcount of BUSY; BUSY[0] is always 0.

## Timing
- Reset (rst_i high at an edge):
  - all REGS <= 0 and all BUSY <= 0;
  - claims and writes presented in the same cycle are ignored;
  - reset mid-operation discards all pending claims.
- After reset:
  - rd_data_o = 0, rd_busy_o = 0, busy_count_o = 0;
  - claim_ready_o follows claim_valid_i.
- Read latency is 0 cycles (combinational).
- Write latency:
  - the written value appears on a read port from the cycle after the edge;
  - BUSY clears at the same edge.
- Claim latency: BUSY is set at the edge where the claim is accepted, so rd_busy_o = 1 from the next cycle.
- No internal pipeline and no state machine beyond the BUSY array.
- busy_count_o changes only at clock edges.

## Configuration
- Macro REGFILE_SCOREBOARD_BYPASS_EN.
- Defined: write-to-read bypass is enabled.
  - If wr_en_i[w] is high and wr_addr_i[w] == rd_addr_i[p] (nonzero), then in the same cycle rd_data_o[p] = wr_data_i[w] (lowest w wins) and rd_busy_o[p] = 0.
  - This removes one stall cycle per RAW hazard.
- Undefined:
  - reads always return the stored REGS and BUSY;
  - a same-cycle write is visible only from the next cycle;
  - the bypass comparators are not synthesised.

## Test plan
- Reset:
  - Stimulus: preload by writing r5=0xDEAD, then assert rst_i for 1 cycle.
  - Response: rd_addr=5 → rd_data_o=0, rd_busy_o=0, busy_count_o=0.
- Claim, then write:
  - Stimulus: claim r3 → next cycle rd_busy_o=1 and busy_count_o=1. Then write r3=0x1234.
  - Response: next cycle rd_data_o=0x1234, rd_busy_o=0, busy_count_o=0.
- Register 0:
  - Stimulus: write x0=0xFFFF and claim x0.
  - Response: claim_ready_o=1; next cycle reads give 0, busy=0, busy_count_o=0.
- WAW refusal and same-cycle reclaim:
  - Stimulus: r7 is busy; claim r7 without a write.
  - Response: claim_ready_o=0 and BUSY is unchanged.
  - Stimulus: claim r7 while writing r7=0x55.
  - Response: claim_ready_o=1; next cycle data=0x55 and busy=1.
- Dual-write collision (NWR=2):
  - Stimulus: both ports write r9, with port 0 = 0xAA and port 1 = 0xBB.
  - Response: next cycle r9 reads 0xAA.
- Bypass:
  - Stimulus: r4 is busy holding 0x10; write r4=0x20 while reading r4 on port 1.
  - Response with REGFILE_SCOREBOARD_BYPASS_EN: same cycle rd_data_o=0x20 and busy=0.
  - Response without the macro: same cycle 0x10 and busy=1; next cycle 0x20 and busy=0.
